// File: rtl/car_motion_fsm.sv
// Elevator car motion controller: moves the car one floor per TRAVEL_CYCLES toward
// the requested destination, then opens the door for DOOR_CYCLES (extendable by door_hold).
module car_motion_fsm #(
  parameter int NUM_FLOORS    = 5,
  parameter int TRAVEL_CYCLES = 50000000,
  parameter int DOOR_CYCLES   = 100000000,
  parameter int CNT_W         = 27
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [2:0]            dest,
  input  logic                  door_hold,
  output logic [1:0]            state,
  output logic [2:0]            location,
  output logic                  door_open,
  output logic                  arrive,
  output logic [NUM_FLOORS-1:0] floor_onehot
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DOOR = 2'd1,
    ST_UP   = 2'd2,
    ST_DOWN = 2'd3
  } car_state_t;

  localparam logic [CNT_W-1:0] TRAVEL_LAST = CNT_W'(TRAVEL_CYCLES - 1);
  localparam logic [CNT_W-1:0] DOOR_LAST   = CNT_W'(DOOR_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
  localparam logic [2:0]       TOP_FLOOR   = 3'(NUM_FLOORS);
  localparam logic [2:0]       BOT_FLOOR   = 3'd1;

  car_state_t            state_q, state_d;
  logic [2:0]            loc_q, loc_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  arrive_q, arrive_d;
  logic                  door_open_q, door_open_d;
  logic [NUM_FLOORS-1:0] onehot_q, onehot_d;

  logic       dest_ok;
  logic [2:0] next_floor;

  // Out-of-range destinations behave exactly like "no request".
  assign dest_ok = (dest != 3'd0) && (dest <= TOP_FLOOR);

  // NOTE: every variable driven here gets a default before any branch, so no
  // path through the block leaves a value unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    loc_d      = loc_q;
    cnt_d      = cnt_q;
    arrive_d   = 1'b0;
    next_floor = loc_q;

    if (enable) begin
      unique case (state_q)
        ST_IDLE: begin
          cnt_d = '0;
          if (dest_ok && (dest > loc_q)) begin
            state_d = ST_UP;
          end else if (dest_ok && (dest < loc_q)) begin
            state_d = ST_DOWN;
          end
        end

        ST_UP: begin
          if (cnt_q == TRAVEL_LAST) begin
            cnt_d      = '0;
            next_floor = loc_q + 3'd1;
            loc_d      = next_floor;
            arrive_d   = 1'b1;
            // Keep climbing only while the request is still strictly above us.
            if ((next_floor == TOP_FLOOR) || !(dest_ok && (dest > next_floor))) begin
              state_d = ST_DOOR;
            end
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end

        ST_DOWN: begin
          if (cnt_q == TRAVEL_LAST) begin
            cnt_d      = '0;
            next_floor = loc_q - 3'd1;
            loc_d      = next_floor;
            arrive_d   = 1'b1;
            if ((next_floor == BOT_FLOOR) || !(dest_ok && (dest < next_floor))) begin
              state_d = ST_DOOR;
            end
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end

        ST_DOOR: begin
          // A held door restarts the dwell and takes priority over expiry.
          if (door_hold) begin
            cnt_d = '0;
          end else if (cnt_q == DOOR_LAST) begin
            cnt_d   = '0;
            state_d = ST_IDLE;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end

        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      endcase
    end

    // Indicator outputs are decoded from next-state values so they register
    // alongside state and location.
    door_open_d = (state_d == ST_DOOR);
    onehot_d    = '0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      onehot_d[i] = (loc_d == 3'(i + 1));
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      loc_q       <= BOT_FLOOR;
      cnt_q       <= '0;
      arrive_q    <= 1'b0;
      door_open_q <= 1'b0;
      onehot_q    <= NUM_FLOORS'(1);
    end else begin
      state_q     <= state_d;
      loc_q       <= loc_d;
      cnt_q       <= cnt_d;
      arrive_q    <= arrive_d;
      door_open_q <= door_open_d;
      onehot_q    <= onehot_d;
    end
  end

  assign state        = state_q;
  assign location     = loc_q;
  assign door_open    = door_open_q;
  assign arrive       = arrive_q;
  assign floor_onehot = onehot_q;

endmodule

// File: tb/tb_car_motion_fsm.sv
// Scoreboard bench for car_motion_fsm: a driver pushes the reference model's expected
// outputs per clock; an independent monitor pops and compares after each rising edge.
module tb_car_motion_fsm;

  localparam int NF     = 5;
  localparam int TRAVEL = 4;
  localparam int DWELL  = 3;

  typedef struct {
    int st;
    int loc;
    int door;
    int arr;
    int oh;
  } exp_t;

  logic          clk;
  logic          reset;
  logic          enable;
  logic [2:0]    dest;
  logic          door_hold;
  logic [1:0]    state;
  logic [2:0]    location;
  logic          door_open;
  logic          arrive;
  logic [NF-1:0] floor_onehot;

  car_motion_fsm #(
    .NUM_FLOORS   (NF),
    .TRAVEL_CYCLES(TRAVEL),
    .DOOR_CYCLES  (DWELL),
    .CNT_W        (27)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .dest        (dest),
    .door_hold   (door_hold),
    .state       (state),
    .location    (location),
    .door_open   (door_open),
    .arrive      (arrive),
    .floor_onehot(floor_onehot)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  exp_t exp_q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;
  bit   done   = 1'b0;

  // Reference model: mode 0 idle, 1 door open, 2 going up, 3 going down.
  // 'spent' is how many enabled cycles the car has already spent in the current leg/dwell.
  int m_mode  = 0;
  int m_floor = 1;
  int m_spent = 0;
  int m_arr   = 0;

  task automatic model_step(input bit r, input bit en, input int d, input bit h);
    bit want;
    int dir;
    m_arr = 0;
    want  = (d >= 1) && (d <= NF);
    if (r) begin
      m_mode = 0; m_floor = 1; m_spent = 0;
    end else if (en) begin
      if (m_mode == 0) begin
        m_spent = 0;
        if (want && d > m_floor) m_mode = 2;
        else if (want && d < m_floor) m_mode = 3;
      end else if (m_mode == 1) begin
        m_spent = h ? 0 : m_spent + 1;
        if (m_spent == DWELL) begin
          m_spent = 0;
          m_mode  = 0;
        end
      end else begin
        dir     = (m_mode == 2) ? 1 : -1;
        m_spent = m_spent + 1;
        if (m_spent == TRAVEL) begin
          m_spent = 0;
          m_floor = m_floor + dir;
          m_arr   = 1;
          if (!(want && (d - m_floor) * dir > 0) || m_floor == NF || m_floor == 1)
            m_mode = 1;
        end
      end
    end
  endtask

  task automatic drive(input bit r, input bit en, input int d, input bit h);
    exp_t e;
    reset     = r;
    enable    = en;
    dest      = 3'(d);
    door_hold = h;
    model_step(r, en, d, h);
    e.st   = m_mode;
    e.loc  = m_floor;
    e.door = (m_mode == 1) ? 1 : 0;
    e.arr  = m_arr;
    e.oh   = 1 << (m_floor - 1);
    exp_q.push_back(e);
    @(posedge clk);
    #2;
  endtask

  task automatic run(input int n, input bit en, input int d, input bit h);
    for (int i = 0; i < n; i++) drive(1'b0, en, d, h);
  endtask

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0d required %0d", name, $time, act, req);
    end
  endtask

  // Monitor: one registered output set appears after every rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (!done) begin
        if (exp_q.size() == 0) begin
          check("scoreboard_empty", 8'd1, 8'd0);
        end else begin
          e = exp_q.pop_front();
          check("state",        8'(state),        8'(e.st));
          check("location",     8'(location),     8'(e.loc));
          check("door_open",    8'(door_open),    8'(e.door));
          check("arrive",       8'(arrive),       8'(e.arr));
          check("floor_onehot", 8'(floor_onehot), 8'(e.oh));
        end
      end
    end
  end

  initial begin
    int d;
    // Reset, then a request for the current floor must not move the car.
    drive(1'b1, 1'b1, 1, 1'b0);
    drive(1'b1, 1'b0, 1, 1'b0);
    run(10, 1'b1, 1, 1'b0);
    // Floor 1 -> 3, dwell, back to idle.
    run(16, 1'b1, 3, 1'b0);
    // Down to 2, then up toward 5 with the request reversed mid-leg.
    run(14, 1'b1, 2, 1'b0);
    run(3, 1'b1, 5, 1'b0);
    run(30, 1'b1, 1, 1'b0);
    // Up to 4, hold the door 10 cycles, then release.
    run(14, 1'b1, 4, 1'b0);
    run(10, 1'b1, 4, 1'b1);
    run(6, 1'b1, 4, 1'b0);
    // Enable pause mid-leg while heading up.
    run(3, 1'b1, 5, 1'b0);
    run(7, 1'b0, 5, 1'b0);
    run(12, 1'b1, 5, 1'b0);
    // Heading down from 5, reset near floor 3, then an invalid request.
    run(10, 1'b1, 1, 1'b0);
    drive(1'b1, 1'b1, 1, 1'b0);
    run(10, 1'b1, 7, 1'b0);
    run(5, 1'b1, 0, 1'b0);
    // Randomized traffic: sticky destinations, occasional pauses, holds and resets.
    d = 3;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 19) == 0) d = $urandom_range(0, 7);
      drive($urandom_range(0, 299) == 0,
            $urandom_range(0, 9) != 0,
            d,
            $urandom_range(0, 7) == 0);
    end
    done = 1'b1;
    if (exp_q.size() != 0) check("scoreboard_leftover", 8'(exp_q.size()), 8'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
